// File: rtl/spi_slave_if.sv
// SPI slave endpoint: synchronizes sclk/cs/mosi into the system clock domain,
// shifts bytes MSB-first, buffers received bytes in a FIFO and sends from a one-byte holding register.
module spi_slave_if #(
    parameter bit         CPOL     = 1'b0,
    parameter bit         CPHA     = 1'b0,
    parameter int         RX_DEPTH = 4,
    parameter logic [7:0] TX_IDLE  = 8'hFF
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic                          sclk,
    input  logic                          cs,
    input  logic                          mosi,
    output logic                          miso,
    output logic                          miso_oe,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(RX_DEPTH):0]     rx_count,
    output logic                          overrun,
    output logic                          underrun,
    output logic                          frame_err,
    input  logic                          clr_err
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;

    // [0]/[1] form the synchronizer, [2] is the one-cycle delay used for edge detection
    logic [2:0] sclk_sync_q;
    logic [2:0] cs_sync_q;
    logic [1:0] mosi_sync_q;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_done_q, byte_done_d;
    logic       und_pend_q, und_pend_d;
    logic       miso_q, miso_d;
    logic [6:0] shift_rx_q, shift_rx_d;
    logic [7:0] shift_tx_q, shift_tx_d;
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       underrun_q, underrun_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic       push_vld_q, push_vld_d;
    logic [7:0] push_data_q, push_data_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [RX_DEPTH];

    logic sclk_now, sclk_prev, cs_now, cs_prev, mosi_s;
    logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;
    logic do_load, reload, tx_wr, pop, full, push_ok;
    logic [7:0] load_byte;

    assign sclk_now    = sclk_sync_q[1];
    assign sclk_prev   = sclk_sync_q[2];
    assign cs_now      = cs_sync_q[1];
    assign cs_prev     = cs_sync_q[2];
    assign mosi_s      = mosi_sync_q[1];
    assign lead_edge   = (sclk_prev == CPOL) && (sclk_now != CPOL);
    assign trail_edge  = (sclk_prev != CPOL) && (sclk_now == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = cs_prev && !cs_now;
    assign cs_rise     = !cs_prev && cs_now;

    assign load_byte = hold_valid_q ? hold_data_q : TX_IDLE;
    assign tx_wr     = tx_valid && !hold_valid_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        und_pend_d  = und_pend_q;
        miso_d      = miso_q;
        shift_rx_d  = shift_rx_q;
        shift_tx_d  = shift_tx_q;
        push_vld_d  = 1'b0;
        push_data_d = push_data_q;
        frame_err_d = 1'b0;
        do_load     = 1'b0;
        reload      = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d   = '0;
                byte_done_d = 1'b0;
                und_pend_d  = 1'b0;
                miso_d      = 1'b0;
                if (cs_fall) state_d = LOAD;
            end
            LOAD: begin
                do_load = 1'b1;
                state_d = XFER;
                if (!CPHA) miso_d = load_byte[7];
            end
            XFER: begin
                if (sample_edge) begin
                    shift_rx_d = {shift_rx_q[5:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    und_pend_d = 1'b0;
                    if (bit_cnt_q == 3'd7) begin
                        push_vld_d  = 1'b1;
                        push_data_d = {shift_rx_q, mosi_s};
                        byte_done_d = 1'b1;
                    end
                end
                if (shift_edge) begin
                    if (bit_cnt_q != 3'd0) begin
                        shift_tx_d = shift_tx_q << 1;
                        miso_d     = shift_tx_q[6];
                    end else if (byte_done_q) begin
                        reload      = 1'b1;
                        byte_done_d = 1'b0;
                        miso_d      = load_byte[7];
                        und_pend_d  = !hold_valid_q;
                    end else begin
                        miso_d = shift_tx_q[7];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (cs_rise) begin
            frame_err_d = (bit_cnt_d != 3'd0);
            state_d     = IDLE;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            und_pend_d  = 1'b0;
            miso_d      = 1'b0;
            do_load     = 1'b0;
            reload      = 1'b0;
        end
        if (do_load || reload) shift_tx_d = load_byte;
    end

    // An idle byte fetched at a byte boundary only counts as underrun once
    // the master actually clocks it, so a frame ending cleanly does not flag it.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        underrun_d   = underrun_q;
        if (do_load || reload) hold_valid_d = 1'b0;
        if (tx_wr) begin
            hold_valid_d = 1'b1;
            hold_data_d  = tx_data;
        end
        if ((do_load && !hold_valid_q) || (sample_edge && und_pend_q && state_q == XFER))
            underrun_d = 1'b1;
        if (clr_err) underrun_d = 1'b0;
    end

    assign pop     = rx_ready && (count_q != '0);
    assign full    = (count_q == CW'(RX_DEPTH));
    assign push_ok = push_vld_q && (!full || pop);

    always_comb begin
        wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push_ok) - CW'(pop);
        overrun_d = overrun_q || (push_vld_q && full && !pop);
        if (clr_err) overrun_d = 1'b0;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= {3{CPOL}};
            cs_sync_q    <= 3'b000;
            mosi_sync_q  <= 2'b00;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            byte_done_q  <= 1'b0;
            und_pend_q   <= 1'b0;
            miso_q       <= 1'b0;
            hold_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            push_vld_q   <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[1:0], sclk};
            cs_sync_q    <= {cs_sync_q[1:0], cs};
            mosi_sync_q  <= {mosi_sync_q[0], mosi};
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_done_q  <= byte_done_d;
            und_pend_q   <= und_pend_d;
            miso_q       <= miso_d;
            hold_valid_q <= hold_valid_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            push_vld_q   <= push_vld_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        shift_rx_q  <= shift_rx_d;
        shift_tx_q  <= shift_tx_d;
        hold_data_q <= hold_data_d;
        push_data_q <= push_data_d;
        if (push_ok) mem_q[wr_ptr_q] <= push_data_q;
    end

    assign miso      = miso_q;
    assign miso_oe   = (state_q != IDLE);
    assign tx_ready  = !hold_valid_q;
    assign rx_valid  = (count_q != '0);
    assign rx_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign rx_count  = count_q;
    assign overrun   = overrun_q;
    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: a mode-0 instance and a CPOL=1/CPHA=1 instance driven by a
// bit-level SPI master task; expected bytes are queued at stimulus time and compared on output.
module tb_spi_slave_if;
    localparam int HALF = 6;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic mosi = 1'b0, clr_err = 1'b0, rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic sclk_a = 1'b0, cs_a = 1'b1, tx_valid_a = 1'b0;
    logic miso_a, miso_oe_a, tx_ready_a, rx_valid_a, overrun_a, underrun_a, frame_err_a;
    logic [7:0] rx_data_a;
    logic [2:0] rx_count_a;

    logic sclk_b = 1'b1, cs_b = 1'b1, tx_valid_b = 1'b0;
    logic miso_b, miso_oe_b, tx_ready_b, rx_valid_b, overrun_b, underrun_b, frame_err_b;
    logic [7:0] rx_data_b;
    logic [2:0] rx_count_b;

    int n_chk = 0, n_pass = 0;
    int fe_a = 0, fe_b = 0;
    int pop_bit = -1;
    logic [7:0] mosi_q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];

    always #5 clock = ~clock;

    spi_slave_if #(.CPOL(1'b0), .CPHA(1'b0), .RX_DEPTH(4), .TX_IDLE(8'hFF)) dut_a (
        .clock(clock), .rst_n(rst_n), .sclk(sclk_a), .cs(cs_a), .mosi(mosi),
        .miso(miso_a), .miso_oe(miso_oe_a), .tx_data(tx_data), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready),
        .rx_count(rx_count_a), .overrun(overrun_a), .underrun(underrun_a),
        .frame_err(frame_err_a), .clr_err(clr_err));

    spi_slave_if #(.CPOL(1'b1), .CPHA(1'b1), .RX_DEPTH(4), .TX_IDLE(8'hFF)) dut_b (
        .clock(clock), .rst_n(rst_n), .sclk(sclk_b), .cs(cs_b), .mosi(mosi),
        .miso(miso_b), .miso_oe(miso_oe_b), .tx_data(tx_data), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready),
        .rx_count(rx_count_b), .overrun(overrun_b), .underrun(underrun_b),
        .frame_err(frame_err_b), .clr_err(clr_err));

    always @(posedge clock) begin
        if (frame_err_a) fe_a++;
        if (frame_err_b) fe_b++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tx_write(input bit sel, input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clock);
        while (((sel ? tx_ready_b : tx_ready_a) == 1'b0) && t < 200) begin
            @(negedge clock);
            t++;
        end
        check_eq("tx_accept", 32'(t < 200), 1);
        tx_data = d;
        if (sel) tx_valid_b = 1'b1; else tx_valid_a = 1'b1;
        @(negedge clock);
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
        exp_miso.push_back(d);
    endtask

    task automatic pop_check(input bit sel, input string tag);
        int t;
        logic [7:0] e;
        t = 0;
        while (((sel ? rx_valid_b : rx_valid_a) == 1'b0) && t < 50) begin
            @(negedge clock);
            t++;
        end
        check_eq({tag, "_vld"}, sel ? rx_valid_b : rx_valid_a, 1);
        if (exp_rx.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = exp_rx.pop_front();
            check_eq(tag, sel ? rx_data_b : rx_data_a, e);
        end
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    // sel=0: CPOL0/CPHA0 on dut_a; sel=1: CPOL1/CPHA1 on dut_b
    task automatic spi_frame(input bit sel, input int nbits);
        logic [7:0] acc, mb_byte, e;
        logic rb;
        acc = 8'h00;
        @(negedge clock);
        if (sel) cs_b = 1'b0; else cs_a = 1'b0;
        repeat (8) @(negedge clock);
        check_eq("miso_oe_active", sel ? miso_oe_b : miso_oe_a, 1);
        for (int k = 0; k < nbits; k++) begin
            mb_byte = mosi_q[k / 8];
            if (!sel) begin
                mosi = mb_byte[7 - (k % 8)];
                repeat (HALF) @(negedge clock);
                sclk_a = 1'b1;
                rb = miso_a;
                if (k == pop_bit) begin
                    repeat (3) @(negedge clock);
                    check_eq("pop_at_push", rx_data_a, exp_rx[0]);
                    void'(exp_rx.pop_front());
                    rx_ready = 1'b1;
                    @(negedge clock);
                    rx_ready = 1'b0;
                    repeat (HALF - 4) @(negedge clock);
                end else begin
                    repeat (HALF) @(negedge clock);
                end
                sclk_a = 1'b0;
            end else begin
                repeat (HALF) @(negedge clock);
                sclk_b = 1'b0;
                mosi = mb_byte[7 - (k % 8)];
                repeat (HALF) @(negedge clock);
                sclk_b = 1'b1;
                rb = miso_b;
            end
            acc = {acc[6:0], rb};
            if (k % 8 == 7) begin
                exp_rx.push_back(mb_byte);
                if (exp_miso.size() != 0) e = exp_miso.pop_front();
                else e = 8'hFF;
                check_eq("master_rx", acc, e);
            end
        end
        repeat (HALF) @(negedge clock);
        if (sel) cs_b = 1'b1; else cs_a = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check_eq("rst_miso", miso_a, 0);
        check_eq("rst_miso_oe", miso_oe_a, 0);
        check_eq("rst_tx_ready", tx_ready_a, 1);
        check_eq("rst_rx_valid", rx_valid_a, 0);
        check_eq("rst_rx_data", rx_data_a, 0);
        check_eq("rst_rx_count", rx_count_a, 0);
        check_eq("rst_overrun", overrun_a, 0);
        check_eq("rst_underrun", underrun_a, 0);
        check_eq("rst_frame_err", frame_err_a, 0);
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        repeat (5) @(negedge clock);

        // single byte, preloaded tx
        tx_write(0, 8'hA5);
        mosi_q = '{8'h3C};
        spi_frame(0, 8);
        check_eq("t1_rx_count", rx_count_a, 1);
        check_eq("t1_overrun", overrun_a, 0);
        check_eq("t1_underrun", underrun_a, 0);
        pop_check(0, "t1_rx");

        // two-byte burst with a tx write during the first byte
        tx_write(0, 8'h11);
        mosi_q = '{8'h81, 8'h7E};
        fork
            spi_frame(0, 16);
            begin
                repeat (20) @(negedge clock);
                tx_write(0, 8'h22);
            end
        join
        check_eq("t2_underrun", underrun_a, 0);
        pop_check(0, "t2_rx0");
        pop_check(0, "t2_rx1");

        // empty holding register
        mosi_q = '{8'h00};
        spi_frame(0, 8);
        check_eq("t3_underrun", underrun_a, 1);
        check_eq("t3_tx_ready", tx_ready_a, 1);
        pop_check(0, "t3_rx");
        clr_err = 1'b1;
        @(negedge clock);
        clr_err = 1'b0;
        check_eq("t3_underrun_clr", underrun_a, 0);

        // overrun: five bytes, no pops
        mosi_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        spi_frame(0, 40);
        void'(exp_rx.pop_back());
        check_eq("t4_rx_count", rx_count_a, 4);
        check_eq("t4_overrun", overrun_a, 1);
        for (int i = 0; i < 4; i++) pop_check(0, "t4_rx");
        clr_err = 1'b1;
        @(negedge clock);
        clr_err = 1'b0;
        check_eq("t4_overrun_clr", overrun_a, 0);

        // pop coinciding with the fifth push
        pop_bit = 39;
        spi_frame(0, 40);
        pop_bit = -1;
        check_eq("t4b_rx_count", rx_count_a, 4);
        check_eq("t4b_overrun", overrun_a, 0);
        for (int i = 0; i < 4; i++) pop_check(0, "t4b_rx");

        // partial byte
        fe_a = 0;
        mosi_q = '{8'hAA};
        spi_frame(0, 5);
        check_eq("t5_frame_err_cycles", fe_a, 1);
        check_eq("t5_frame_err_now", frame_err_a, 0);
        check_eq("t5_rx_count", rx_count_a, 0);
        check_eq("t5_miso_oe", miso_oe_a, 0);
        mosi_q = '{8'h96};
        spi_frame(0, 8);
        pop_check(0, "t5_rx_next");

        // CPOL=1 CPHA=1 exchange
        tx_write(1, 8'h5A);
        mosi_q = '{8'hC3};
        spi_frame(1, 8);
        pop_check(1, "t6_rx");

        // reset in the middle of a byte, cs kept low across release
        fe_b = 0;
        mosi_q = '{8'h0F};
        fork
            spi_frame(1, 6);
            begin
                repeat (30) @(negedge clock);
                tx_write(1, 8'h77);
                check_eq("t7_pre_miso_oe", miso_oe_b, 1);
                check_eq("t7_pre_tx_ready", tx_ready_b, 0);
                check_eq("t7_pre_underrun", underrun_b, 1);
                #2;
                rst_n = 1'b0;
                #1;
                check_eq("t7_miso", miso_b, 0);
                check_eq("t7_miso_oe", miso_oe_b, 0);
                check_eq("t7_tx_ready", tx_ready_b, 1);
                check_eq("t7_rx_valid", rx_valid_b, 0);
                check_eq("t7_rx_data", rx_data_b, 0);
                check_eq("t7_rx_count", rx_count_b, 0);
                check_eq("t7_overrun", overrun_b, 0);
                check_eq("t7_underrun", underrun_b, 0);
                check_eq("t7_frame_err", frame_err_b, 0);
                exp_miso.delete();
                repeat (3) @(negedge clock);
                rst_n = 1'b1;
            end
        join
        check_eq("t7_no_restart_fe", fe_b, 0);
        check_eq("t7_no_restart_rx", rx_valid_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

SPI slave (responder) endpoint: the far end of the simple_spi master link in the SPI testbench top. It samples sclk, cs and mosi into the system clock domain and shifts bytes in and out MSB-first. Received bytes go to an RX FIFO with a valid/ready output. Transmit bytes come from a one-entry holding register with a valid/ready input. The block serves as a synthesizable loopback/echo target for the SPI bench and as a reusable peripheral-side SPI port.

## Interface
- CPOL, 0, sclk idle level.
- CPHA, 0, 0: sample on the leading edge, shift on the trailing edge; 1: shift on the leading edge, sample on the trailing edge.
- RX_DEPTH, 4, RX FIFO entries (power of 2, ≥2).
- TX_IDLE, 8'hFF, byte shifted out when the holding register is empty.
- clock  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sclk  input  1  SPI serial clock from the master (asynchronous).
- cs  input  1  slave select, active low (asynchronous).
- mosi  input  1  master out, slave in.
- miso  output  1  master in, slave out.
- miso_oe  output  1  high while cs is synchronized low.
- tx_data  input  8  next byte to send.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register is empty.
- rx_data  output  8  head of the RX FIFO.
- rx_valid  output  1  RX FIFO is not empty.
- rx_ready  input  1  pops the RX FIFO head.
- rx_count  output  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- overrun  output  1  sticky: a byte was received while the FIFO was full.
- underrun  output  1  sticky: TX_IDLE was sent because no tx byte was available.
- frame_err  output  1  one-cycle pulse: cs rose with a partial byte received.
- clr_err  input  1  clears overrun and underrun.

## Operation
- Synchronization: sclk, cs and mosi each pass through a 2-flop synchronizer. Edges of sclk and cs are detected from the synchronized value and its one-cycle delay.
- Leading edge is sclk leaving CPOL; trailing edge is sclk returning to CPOL.
- States:
  - IDLE (cs high): bit_cnt=0, miso_oe=0, miso=0. The synchronized cs falling edge goes to LOAD.
  - LOAD (1 cycle): shift_tx takes the holding register if it is valid, which sets tx_ready; otherwise shift_tx takes TX_IDLE and underrun is set. With CPHA=0, miso takes shift_tx[7] now. Next state is XFER.
  - XFER:
    - Sample edge: shift_rx = {shift_rx[6:0], mosi_sync}; bit_cnt increments.
    - Shift edge: miso takes the next bit, MSB first.
    - CPHA=1: the first leading edge after LOAD drives shift_tx[7].
    - After the 8th sample: push {shift_rx[6:0], mosi_sync} into the FIFO and set bit_cnt=0.
    - Byte boundary: the next shift edge reloads as in LOAD. With CPHA=0, the reload happens on the trailing edge after the 8th sample, and that edge drives the new MSB.
- cs rising (synchronized) in any state → IDLE. If bit_cnt≠0, the partial byte is discarded and frame_err pulses. Complete bytes already pushed are kept.
- RX FIFO behaviour:
  - Full with no pop: the push is dropped and overrun sets.
  - Full with a simultaneous pop: the push is accepted and overrun is not set.
- tx handshake: a write occurs when tx_valid && tx_ready. A load and a write in the same cycle are both honoured: the load takes the old content, then the new byte is stored.
- clr_err takes priority over a same-cycle set.

## Timing
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, rx_count=0, overrun=0, underrun=0, frame_err=0. State is IDLE and the FIFO is empty.
- Pin-to-action latency: 3 clock cycles from an sclk or cs pin edge to a miso update, FIFO push, or LOAD.
- rx_valid rises 4 cycles after the 8th sample edge at the pin.
- Constraints on the master side:
  - sclk period ≥ 8 clock periods (high and low phases ≥ 4 each).
  - First sclk edge ≥ 4 clocks after cs falls.
  - cs high time ≥ 3 clocks.
- Reset mid-transfer: everything returns to its reset value immediately (asynchronous). The block then waits in IDLE for a fresh cs falling edge, even if cs is still low at reset release.

## Test plan
- Mode 0, tx_data=8'hA5 preloaded, master sends 8'h3C: master reads 8'hA5; rx_data=8'h3C, rx_count=1; overrun and underrun stay 0.
- Two-byte burst under one cs low, tx writes 8'h11 then 8'h22, master sends 8'h81, 8'h7E: master reads 8'h11, 8'h22; FIFO pops 8'h81, 8'h7E in order.
- Empty holding register, master sends 8'h00: master reads 8'hFF and underrun=1. clr_err clears it; tx_ready=1 throughout.
- RX_DEPTH=4, rx_ready=0, master sends 5 bytes 8'h01..8'h05: rx_count=4, overrun=1, FIFO holds 8'h01..8'h04. Repeat with a pop coinciding with the 5th push: no overrun.
- cs deasserted after 5 bits: frame_err is a one-cycle pulse, rx_count unchanged, miso_oe=0. The next full byte is received correctly.
- CPOL=1, CPHA=1 build, exchange 8'hC3 ↔ 8'h5A: both sides receive the correct byte. rst_n asserted mid-byte: all outputs take their reset values within the same cycle.
